// File: rtl/xadac_pkg.sv
// Shared payload types for the XADAC coprocessor link.
// Contents: ID and data widths, plus the packed payloads for the
// decode and execute request/response channels.
package xadac_pkg;

  localparam int unsigned IdWidth    = 4;
  localparam int unsigned InstrWidth = 32;
  localparam int unsigned DataWidth  = 32;

  typedef logic [IdWidth-1:0] id_t;

  // Decode request: instruction offered to the accelerator for decoding.
  typedef struct packed {
    id_t                   id;
    logic [InstrWidth-1:0] instr;
  } DecReqT;

  // Decode response: whether the accelerator takes the instruction.
  typedef struct packed {
    id_t  id;
    logic accept;
    logic rd_write;
  } DecRspT;

  // Execute request: accepted instruction with its source operand.
  typedef struct packed {
    id_t                   id;
    logic [InstrWidth-1:0] instr;
    logic [DataWidth-1:0]  rs1;
  } ExeReqT;

  // Execute response: result value and error flag.
  typedef struct packed {
    id_t                  id;
    logic [DataWidth-1:0] rd;
    logic                 error;
  } ExeRspT;

endpackage

// File: rtl/xadac_if.sv
// XADAC link bundle: four valid/ready channels.
// dec_req/exe_req travel master -> slave; dec_rsp/exe_rsp travel
// slave -> master. Modport mst is the requesting side, slv the serving side.
interface xadac_if;
  import xadac_pkg::*;

  logic   dec_req_valid;
  logic   dec_req_ready;
  DecReqT dec_req_data;

  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  DecRspT dec_rsp_data;

  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeReqT exe_req_data;

  logic   exe_rsp_valid;
  logic   exe_rsp_ready;
  ExeRspT exe_rsp_data;

  modport mst (
    output dec_req_valid, dec_req_data, input  dec_req_ready,
    input  dec_rsp_valid, dec_rsp_data, output dec_rsp_ready,
    output exe_req_valid, exe_req_data, input  exe_req_ready,
    input  exe_rsp_valid, exe_rsp_data, output exe_rsp_ready
  );

  modport slv (
    input  dec_req_valid, dec_req_data, output dec_req_ready,
    output dec_rsp_valid, dec_rsp_data, input  dec_rsp_ready,
    input  exe_req_valid, exe_req_data, output exe_req_ready,
    output exe_rsp_valid, exe_rsp_data, input  exe_rsp_ready
  );

endinterface

// File: rtl/xadac_spill_reg.sv
// Two-entry in-order spill buffer for one valid/ready channel.
// Ports: clk, rst_n (async, active-low); input side in_valid/in_ready/in_data;
// output side out_valid/out_ready/out_data.
// Bypass=1 turns the block into plain wires (zero latency).
// With Bypass=0, in_ready, out_valid and out_data depend only on registers.
module xadac_spill_reg #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  if (Bypass) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;

    // Clock and reset have no purpose in the wire-through variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end else begin : g_cut
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       rd_ptr_q;
    logic       wr_ptr;
    logic       push;
    logic       pop;
    T           slot_q [2];

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = slot_q[rd_ptr_q];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Next free slot: the head slot when empty, the other one when holding one.
    assign wr_ptr = rd_ptr_q ^ count_q[0];

    // Occupancy update; push+pop together leaves count unchanged.
    always_comb begin
      count_d = count_q;
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (!push && pop) begin
        count_d = count_q - 2'd1;
      end
    end

    // State and payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q   <= 2'd0;
        rd_ptr_q  <= 1'b0;
        slot_q[0] <= '0;
        slot_q[1] <= '0;
      end else begin
        count_q <= count_d;
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        if (push) begin
          slot_q[wr_ptr] <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/xadac_cut.sv
// Registered pipeline cut for the XADAC link.
// Ports: clk_i, rst_ni (async, active-low); slv faces the core-side master,
// mst faces the accelerator (or the next cut).
// CutDec/CutExe select buffering of the decode and execute channel pairs;
// a disabled pair is wired straight through.
module xadac_cut
  import xadac_pkg::*;
#(
  parameter bit CutDec = 1'b1,
  parameter bit CutExe = 1'b1
) (
  input logic   clk_i,
  input logic   rst_ni,
  xadac_if.slv  slv,
  xadac_if.mst  mst
);

  // Decode request: slv -> mst.
  xadac_spill_reg #(.T(DecReqT), .Bypass(CutDec == 1'b0)) u_dec_req (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (slv.dec_req_valid),
    .in_ready  (slv.dec_req_ready),
    .in_data   (slv.dec_req_data),
    .out_valid (mst.dec_req_valid),
    .out_ready (mst.dec_req_ready),
    .out_data  (mst.dec_req_data)
  );

  // Decode response: mst -> slv.
  xadac_spill_reg #(.T(DecRspT), .Bypass(CutDec == 1'b0)) u_dec_rsp (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (mst.dec_rsp_valid),
    .in_ready  (mst.dec_rsp_ready),
    .in_data   (mst.dec_rsp_data),
    .out_valid (slv.dec_rsp_valid),
    .out_ready (slv.dec_rsp_ready),
    .out_data  (slv.dec_rsp_data)
  );

  // Execute request: slv -> mst.
  xadac_spill_reg #(.T(ExeReqT), .Bypass(CutExe == 1'b0)) u_exe_req (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (slv.exe_req_valid),
    .in_ready  (slv.exe_req_ready),
    .in_data   (slv.exe_req_data),
    .out_valid (mst.exe_req_valid),
    .out_ready (mst.exe_req_ready),
    .out_data  (mst.exe_req_data)
  );

  // Execute response: mst -> slv.
  xadac_spill_reg #(.T(ExeRspT), .Bypass(CutExe == 1'b0)) u_exe_rsp (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (mst.exe_rsp_valid),
    .in_ready  (mst.exe_rsp_ready),
    .in_data   (mst.exe_rsp_data),
    .out_valid (slv.exe_rsp_valid),
    .out_ready (slv.exe_rsp_ready),
    .out_data  (slv.exe_rsp_data)
  );

endmodule

// File: doc/xadac_cut.md
# xadac_cut

Registered pipeline cut for the XADAC coprocessor link. Sits between an `xadac_if` master (the core-side dispatcher) and an `xadac_if` slave (the accelerator, or the next cut). Inserts a full-throughput two-entry spill buffer on each of the four channels: dec_req, dec_rsp, exe_req and exe_rsp. The buffer breaks the valid/data and ready timing paths without reordering or dropping transfers.

## Interface

Parameters:
- `CutDec`, default 1: when 1, dec_req and dec_rsp are buffered; when 0, both pass through as wires.
- `CutExe`, default 1: when 1, exe_req and exe_rsp are buffered; when 0, both pass through as wires.

Ports:
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `slv`  xadac_if.slv  bundle  upstream side; connects to the master. Receives dec_req and exe_req, returns dec_rsp and exe_rsp.
- `mst`  xadac_if.mst  bundle  downstream side; connects to the slave. Forwards dec_req and exe_req, receives dec_rsp and exe_rsp.

Clocking and reset are fixed: one clock (`clk_i`), with an asynchronous, active-low reset (`rst_ni`).

## Operation

- Each buffered channel is an independent 2-entry in-order FIFO with input side (in_valid, in_ready, in_data) and output side (out_valid, out_ready, out_data).
- Channel direction:
  - dec_req and exe_req flow slv→mst.
  - dec_rsp and exe_rsp flow mst→slv.
- State per channel: `count` ∈ {0,1,2}, two payload slots, one read pointer.
- Output side:
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - out_data = slot[rd_ptr].
- A push happens when in_valid && in_ready. A pop happens when out_valid && out_ready.
- Count update per cycle:
  - push only → count+1.
  - pop only → count−1, rd_ptr toggles.
  - push and pop together → count unchanged, rd_ptr toggles, the new entry is written to the freed or next slot.
- Boundary conditions:
  - count=2: in_ready=0, so push is impossible. A pop that cycle drops count to 1, and in_ready rises in the next cycle.
  - count=0: no pop is possible. A push makes out_valid=1 in the next cycle. There is no same-cycle bypass.
  - Payload of a stalled entry stays stable while out_valid=1 && out_ready=0. This is the AXI-style valid-stability rule, and the block guarantees it.
- Channels never interact. Back-pressure on exe_rsp must not affect dec_req.
- Reset mid-operation: all counts go to 0 immediately, and any buffered transfers are discarded. Upstream must also be reset.
- Payload types are the package types and are not modified.

## Timing

- Reset values:
  - all out_valid = 0.
  - all in_ready = 1 (count=0).
  - all out_data = '0.
  - rd_ptr = 0.
- Latency with a cut enabled: exactly 1 cycle, from push to out_valid.
- Throughput: 1 transfer/cycle sustained, with continuous valid and ready.
- With a cut enabled, in_ready depends only on registers; there is no combinational path from out_ready to in_ready.
- out_valid and out_data depend only on registers.
- With a cut disabled (`CutDec=0` or `CutExe=0`), latency is 0 cycles, and all signals of that pair connect directly.

## Structure

- Payload types `DecReqT`, `DecRspT`, `ExeReqT` and `ExeRspT` come from `xadac_pkg`. No new package content is needed.
- Sub-module `xadac_spill_reg`, parameterized by type `T` and bit `Bypass`, holds the channel FIFO described above. `xadac_cut` instantiates it four times.
- Estimated size: about 100 lines for `xadac_spill_reg` plus about 60 for the top.

## Test plan

- Reset: hold `rst_ni`=0 and drive every in_valid=1. Required: all out_valid=0, all in_ready=1, no push recorded. After release, the first push appears at the output one cycle later.
- Streaming: push dec_req payloads 1..16 back-to-back with mst.dec_req_ready=1 throughout. Required: 16 outputs in order, first one a cycle after the first push, no bubbles, slv.dec_req_ready stays 1.
- Full stall: hold exe_req_ready=0 and push A, B, C. Required:
  - A and B accepted; ready drops after B and C is held.
  - Output stays A, stable for 5 cycles.
  - Release ready: outputs A, B, C in order; C is accepted the cycle after A pops.
- Simultaneous push/pop at count=1: hold count=1, then drive push and pop in the same cycle for 10 cycles. Required: count stays 1, order is preserved, out_valid never drops.
- Independence: stall dec_rsp (dec_rsp_ready=0) while streaming exe_req/exe_rsp. Required: the exe channels keep full throughput, and at most 2 dec_rsp are held.
- Bypass: build with `CutDec=0`, `CutExe=0`. Required: every mst and slv signal follows its counterpart in the same cycle with identical values. Random back-pressure stays stable and no transfers are lost (scoreboard check).
